select_encoder_seq: RTL and testbench
=====================================

Name: select_encoder_seq

Overview:
- Parametrised successor to the datapath select-and-encode stage. Latches the IR and decodes opcode, sign-extended immediate and the Ra/Rb/Rc register fields into one-hot register-file in/out enables.
- Adds a registered selection with hold, an automatic operand-sequencing FSM (start/busy/done handshake) and R0-as-zero handling for BAout.
- Range checking for out-of-range register indices.
- Sits between the control unit and the register file.

Parameters:
DATA_W, 32, IR and immediate output width
SEL_W, 4, width of each register field
NUM_REGS, 16, registers implemented, must be 2..2**SEL_W
OP_W, 5, opcode width, taken from IR MSBs
IMM_W, 18, immediate width in IR[IMM_W-1:0], sign-extended to DATA_W

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-low reset
ir  in  DATA_W  instruction word
ir_load  in  1  capture ir into ir_q
gra  in  1  manual select Ra field
grb  in  1  manual select Rb field
grc  in  1  manual select Rc field
rIN  in  1  enable write to the selected register
rOUT  in  1  enable read of the selected register
baOUT  in  1  base-address read of the selected register; R0 reads as zero
start  in  1  begin auto operand sequence Ra, Rb, Rc
op  out  OP_W  ir_q[DATA_W-1 -: OP_W]
data_sign  out  DATA_W  sign-extended ir_q[IMM_W-1:0]
reg_in  out  NUM_REGS  one-hot register write enables
reg_out  out  NUM_REGS  one-hot register read enables
decode  out  SEL_W  currently selected register index
r0_zero  out  1  high when baOUT targets R0; the bus must drive 0
busy  out  1  sequencer active
done  out  1  one-cycle pulse at the end of a sequence
seq_field  out  2  field being driven by the sequencer: 0=none, 1=Ra, 2=Rb, 3=Rc
sel_err  out  1  sticky flag: an index >= NUM_REGS was selected

Behaviour:
- Reset (clr=0 at a rising edge): ir_q=0, sel_q=0, FSM in IDLE, busy=0, done=0, seq_field=0, sel_err=0.
  - Hence op=0, data_sign=0, decode=0, reg_in=0, reg_out=0, r0_zero=0.
  - Reset has priority over every input, including mid-sequence; the sequence is aborted with no done pulse.
- IR: ir_q<=ir at the edge where ir_load=1. op and data_sign are combinational from ir_q, i.e. valid the cycle after the load.
- Field extraction:
  - Ra = ir_q[DATA_W-OP_W-1 -: SEL_W]
  - Rb = the next SEL_W bits below Ra
  - Rc = the next SEL_W bits below Rb
- Manual select (IDLE only):
  - Priority grc > grb > gra.
  - sel_next = the chosen field; if none asserted, sel_next = sel_q (hold).
  - decode = sel_next combinationally; sel_q<=sel_next each edge.
  - Zero-latency: enables appear in the same cycle as gra/grb/grc.
- Enables:
  - onehot = 1<<decode when decode<NUM_REGS, else all zeros.
  - reg_in = onehot & {rIN}.
  - reg_out = onehot & {rOUT|baOUT}, except when baOUT=1 and decode=0: bit 0 is forced 0 and r0_zero=1.
  - rOUT=1 together with baOUT=1 on R0: baOUT wins, and r0_zero=1.
- sel_err: set at an edge where decode>=NUM_REGS and any of rIN/rOUT/baOUT is high. Cleared only by reset.
- Sequencer FSM, states IDLE, SEQ_A, SEQ_B, SEQ_C, DONE:
  - IDLE: start=1 moves to SEQ_A at the next edge.
  - SEQ_A, SEQ_B, SEQ_C: one cycle each. decode is forced to Ra, Rb, Rc respectively; seq_field is 1, 2, 3; busy=1.
  - reg_out uses rOUT/baOUT as applied externally, with the same R0 rule.
  - During the sequence, reg_in is forced to 0, and gra/grb/grc and start are ignored.
  - DONE: done=1, busy=0, seq_field=0 for one cycle, then IDLE.
    - sel_q retains Rc.
    - A start asserted in DONE is ignored.
  - Latency: start at edge N gives SEQ_A visible in cycle N+1 and done in cycle N+4.
- ir_load during a sequence updates ir_q. Fields already being decoded take the new ir_q value from the following cycle, so the sequence reads live ir_q.
- All state is synchronous to clk; no latches. decode is a pure function of state and inputs.

Test Plan:
- Reset sequencing:
  - Drive clr=0 mid-sequence (SEQ_B) with ir_q nonzero -> the next cycle has all outputs 0, busy=0, and no done pulse.
- Load and manual select:
  - ir=32'h1A2C_0005 loaded -> op=5'h03, Ra=4, Rb=5, Rc=8.
  - grb=1, rOUT=1 -> reg_out=16'h0020 in the same cycle; decode stays 5 after grb drops.
- Priority and R0 rule:
  - gra=grc=1 with Rc=0, baOUT=1 -> decode=0, reg_out=0, r0_zero=1.
  - Same with rIN=1 -> reg_in=16'h0001.
- Sign extension:
  - ir[17:0]=18'h20001 -> data_sign=32'hFFFE_0001.
  - ir[17:0]=18'h1FFFF -> 32'h0001_FFFF.
- Auto sequence, using the IR from the load scenario:
  - start at cycle 0 with rOUT=1 -> reg_out is 0x0010, 0x0020, 0x0100 in cycles 1-3; seq_field=1,2,3; done=1 in cycle 4; gra pulsed in cycle 2 has no effect.
- Range error, with NUM_REGS=12:
  - Select field value 13 with rIN=1 -> reg_in=0, sel_err=1, and sel_err stays set until clr=0.

Source files
------------

// File: rtl/select_encoder_seq.sv
// ============================================================================
// Module   : select_encoder_seq
// Purpose  : Instruction-register latch plus register-field select/encode
//            stage. Decodes opcode, sign-extended immediate and the Ra/Rb/Rc
//            fields into one-hot register-file write/read enables. Supports
//            manual field selection with hold, an automatic Ra->Rb->Rc
//            operand sequencer (start/busy/done) and R0-reads-as-zero on
//            base-address reads. Flags out-of-range register indices.
// Ports    :
//   clk        in   rising-edge clock
//   clr        in   synchronous active-low reset
//   ir         in   instruction word, captured when ir_load=1
//   ir_load    in   load strobe for the instruction register
//   gra/grb/grc in  manual field select (grc > grb > gra), IDLE only
//   rIN        in   write enable for the selected register
//   rOUT       in   read enable for the selected register
//   baOUT      in   base-address read; R0 reads as zero
//   start      in   launch the Ra, Rb, Rc operand sequence
//   op         out  opcode field of the latched IR
//   data_sign  out  sign-extended immediate of the latched IR
//   reg_in     out  one-hot register write enables
//   reg_out    out  one-hot register read enables
//   decode     out  currently selected register index
//   r0_zero    out  bus must drive zero (baOUT on R0)
//   busy       out  sequencer active
//   done       out  one-cycle end-of-sequence pulse
//   seq_field  out  field driven by sequencer: 0 none, 1 Ra, 2 Rb, 3 Rc
//   sel_err    out  sticky out-of-range selection flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module select_encoder_seq #(
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 4,
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5,
  parameter int IMM_W    = 18
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [DATA_W-1:0]   ir,
  input  logic                ir_load,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rIN,
  input  logic                rOUT,
  input  logic                baOUT,
  input  logic                start,
  output logic [OP_W-1:0]     op,
  output logic [DATA_W-1:0]   data_sign,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [SEL_W-1:0]    decode,
  output logic                r0_zero,
  output logic                busy,
  output logic                done,
  output logic [1:0]          seq_field,
  output logic                sel_err
);

  localparam int RA_MSB = DATA_W - OP_W - 1;
  localparam int RB_MSB = RA_MSB - SEL_W;
  localparam int RC_MSB = RB_MSB - SEL_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEQ_A = 3'd1,
    S_SEQ_B = 3'd2,
    S_SEQ_C = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   ir_q;
  logic [SEL_W-1:0]    sel_q;
  logic [SEL_W-1:0]    sel_d;
  logic                busy_q;
  logic                done_q;
  logic [1:0]          seq_field_q;
  logic                sel_err_q;
  logic [NUM_REGS-1:0] onehot;
  logic [SEL_W-1:0]    ra_w;
  logic [SEL_W-1:0]    rb_w;
  logic [SEL_W-1:0]    rc_w;

  // Fields always come from the live ir_q, so an ir_load mid-sequence is
  // seen by the field decoded in the following cycle.
  assign ra_w = ir_q[RA_MSB -: SEL_W];
  assign rb_w = ir_q[RB_MSB -: SEL_W];
  assign rc_w = ir_q[RC_MSB -: SEL_W];

  assign op        = ir_q[DATA_W-1 -: OP_W];
  assign data_sign = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  // Selection: sequencer overrides manual selects; DONE simply holds.
  always_comb begin
    sel_d = sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (grc)      sel_d = rc_w;
        else if (grb) sel_d = rb_w;
        else if (gra) sel_d = ra_w;
      end
      S_SEQ_A: sel_d = ra_w;
      S_SEQ_B: sel_d = rb_w;
      S_SEQ_C: sel_d = rc_w;
      default: sel_d = sel_q;
    endcase
  end

  assign decode = sel_d;

  // Indices beyond NUM_REGS match no bit, so the one-hot vector is all
  // zeros for them; that same all-zero condition flags the range error.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = (sel_d == SEL_W'(i));
    end
  end

  assign r0_zero = baOUT && (sel_d == '0);
  assign reg_in  = (rIN && !busy_q) ? onehot : '0;

  always_comb begin
    reg_out = (rOUT || baOUT) ? onehot : '0;
    if (r0_zero) begin
      reg_out[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      seq_field_q <= 2'd0;
      sel_err_q   <= 1'b0;
    end else begin
      if (ir_load) begin
        ir_q <= ir;
      end
      sel_q <= sel_d;
      if ((onehot == '0) && (rIN || rOUT || baOUT)) begin
        sel_err_q <= 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_SEQ_A;
            busy_q      <= 1'b1;
            seq_field_q <= 2'd1;
          end
          done_q <= 1'b0;
        end
        S_SEQ_A: begin
          state_q     <= S_SEQ_B;
          seq_field_q <= 2'd2;
        end
        S_SEQ_B: begin
          state_q     <= S_SEQ_C;
          seq_field_q <= 2'd3;
        end
        S_SEQ_C: begin
          state_q     <= S_DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          seq_field_q <= 2'd0;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          seq_field_q <= 2'd0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign seq_field = seq_field_q;
  assign sel_err   = sel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_select_encoder_seq.sv
`default_nettype none

module tb_select_encoder_seq;

  logic        clk = 1'b0;
  logic        clr, ir_load, gra, grb, grc, rIN, rOUT, baOUT, start;
  logic [31:0] ir;

  always #5 clk = ~clk;

  // 16-register instance
  logic [4:0]  a_op;
  logic [31:0] a_ds;
  logic [15:0] a_rin, a_rout;
  logic [3:0]  a_dec;
  logic        a_r0, a_busy, a_done, a_err;
  logic [1:0]  a_sf;

  // 12-register instance, same stimulus
  logic [4:0]  b_op;
  logic [31:0] b_ds;
  logic [11:0] b_rin, b_rout;
  logic [3:0]  b_dec;
  logic        b_r0, b_busy, b_done, b_err;
  logic [1:0]  b_sf;

  select_encoder_seq #(.NUM_REGS(16)) dut_a (
    .clk(clk), .clr(clr), .ir(ir), .ir_load(ir_load),
    .gra(gra), .grb(grb), .grc(grc), .rIN(rIN), .rOUT(rOUT), .baOUT(baOUT),
    .start(start), .op(a_op), .data_sign(a_ds), .reg_in(a_rin),
    .reg_out(a_rout), .decode(a_dec), .r0_zero(a_r0), .busy(a_busy),
    .done(a_done), .seq_field(a_sf), .sel_err(a_err)
  );

  select_encoder_seq #(.NUM_REGS(12)) dut_b (
    .clk(clk), .clr(clr), .ir(ir), .ir_load(ir_load),
    .gra(gra), .grb(grb), .grc(grc), .rIN(rIN), .rOUT(rOUT), .baOUT(baOUT),
    .start(start), .op(b_op), .data_sign(b_ds), .reg_in(b_rin),
    .reg_out(b_rout), .decode(b_dec), .r0_zero(b_r0), .busy(b_busy),
    .done(b_done), .seq_field(b_sf), .sel_err(b_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1..3 sequencing Ra/Rb/Rc, 4 done
  logic [31:0] m_ir;
  int          m_sel, m_phase;
  bit          m_err16, m_err12, m_valid = 0;

  function automatic int fld(input int k);
    return int'((m_ir >> (27 - 4 * k)) & 32'hF);
  endfunction

  function automatic int cur_sel();
    if (m_phase >= 1 && m_phase <= 3) return fld(m_phase);
    if (m_phase == 0) begin
      if (grc) return fld(3);
      if (grb) return fld(2);
      if (gra) return fld(1);
    end
    return m_sel;
  endfunction

  function automatic logic [31:0] exp_rin(input int s, input int n);
    if (rIN && !(m_phase >= 1 && m_phase <= 3) && s < n) return 32'd1 << s;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_rout(input int s, input int n);
    if ((rOUT || baOUT) && s < n && !(baOUT && s == 0)) return 32'd1 << s;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_ds();
    return m_ir[17] ? ({14'd0, m_ir[17:0]} | 32'hFFFC_0000) : {14'd0, m_ir[17:0]};
  endfunction

  always @(posedge clk) begin
    int s;
    if (!clr) begin
      m_ir = 0; m_sel = 0; m_phase = 0; m_err16 = 0; m_err12 = 0; m_valid = 1;
    end else if (m_valid) begin
      s = cur_sel();
      if (rIN || rOUT || baOUT) begin
        if (s >= 16) m_err16 = 1;
        if (s >= 12) m_err12 = 1;
      end
      m_sel = s;
      if (ir_load) m_ir = ir;
      case (m_phase)
        0:       m_phase = start ? 1 : 0;
        4:       m_phase = 0;
        default: m_phase = m_phase + 1;
      endcase
    end
  end

  always @(negedge clk) begin
    int s;
    if (m_valid) begin
      s = cur_sel();
      check("op",        32'(a_op),   m_ir >> 27);
      check("data_sign", a_ds,        exp_ds());
      check("decode",    32'(a_dec),  32'(s));
      check("reg_in16",  32'(a_rin),  exp_rin(s, 16));
      check("reg_out16", 32'(a_rout), exp_rout(s, 16));
      check("r0_zero",   32'(a_r0),   32'(baOUT && s == 0));
      check("busy",      32'(a_busy), 32'(m_phase >= 1 && m_phase <= 3));
      check("done",      32'(a_done), 32'(m_phase == 4));
      check("seq_field", 32'(a_sf),   (m_phase >= 1 && m_phase <= 3) ? 32'(m_phase) : 32'd0);
      check("sel_err16", 32'(a_err),  32'(m_err16));
      check("decode12",  32'(b_dec),  32'(s));
      check("reg_in12",  32'(b_rin),  exp_rin(s, 12));
      check("reg_out12", 32'(b_rout), exp_rout(s, 12));
      check("r0_zero12", 32'(b_r0),   32'(baOUT && s == 0));
      check("done12",    32'(b_done), 32'(m_phase == 4));
      check("sel_err12", 32'(b_err),  32'(m_err12));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    ir = v; ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    #2;
  endtask

  initial begin
    clr = 0; ir = 0; ir_load = 0; gra = 0; grb = 0; grc = 0;
    rIN = 0; rOUT = 0; baOUT = 0; start = 0;
    step(); step();
    #2;
    check("lit_rst_op",   32'(a_op),   32'd0);
    check("lit_rst_busy", 32'(a_busy), 32'd0);
    check("lit_rst_err",  32'(a_err),  32'd0);
    check("lit_rst_dec",  32'(a_dec),  32'd0);
    clr = 1;

    // load and manual select
    load(32'h1A2C_0005);
    check("lit_op",  32'(a_op), 32'h03);
    check("lit_ds5", a_ds,      32'h0000_0005);
    grb = 1; rOUT = 1; #2;
    check("lit_grb_rout", 32'(a_rout), 32'h0020);
    check("lit_grb_dec",  32'(a_dec),  32'd5);
    step(); grb = 0; #2;
    check("lit_hold_dec",  32'(a_dec),  32'd5);
    check("lit_hold_rout", 32'(a_rout), 32'h0020);
    step(); rOUT = 0;

    // priority and R0 rule (Rc = 0)
    load(32'h1A28_0000);
    gra = 1; grc = 1; baOUT = 1; #2;
    check("lit_r0_dec",  32'(a_dec),  32'd0);
    check("lit_r0_rout", 32'(a_rout), 32'd0);
    check("lit_r0_flag", 32'(a_r0),   32'd1);
    rIN = 1; rOUT = 1; #1;
    check("lit_r0_rin",   32'(a_rin),  32'h0001);
    check("lit_r0_rout2", 32'(a_rout), 32'd0);
    step(); gra = 0; grc = 0; baOUT = 0; rIN = 0; rOUT = 0;

    // sign extension
    load(32'h1A2E_0001);
    check("lit_sext_neg", a_ds, 32'hFFFE_0001);
    load(32'h1A2D_FFFF);
    check("lit_sext_pos", a_ds, 32'h0001_FFFF);

    // auto sequence
    load(32'h1A2C_0005);
    rOUT = 1; start = 1;
    step(); start = 0; #2;
    check("lit_seqA_rout", 32'(a_rout), 32'h0010);
    check("lit_seqA_sf",   32'(a_sf),   32'd1);
    check("lit_seqA_busy", 32'(a_busy), 32'd1);
    step(); gra = 1; #2;
    check("lit_seqB_rout", 32'(a_rout), 32'h0020);
    check("lit_seqB_sf",   32'(a_sf),   32'd2);
    step(); gra = 0; #2;
    check("lit_seqC_rout", 32'(a_rout), 32'h0100);
    check("lit_seqC_sf",   32'(a_sf),   32'd3);
    step(); start = 1; #2;
    check("lit_done",      32'(a_done), 32'd1);
    check("lit_done_busy", 32'(a_busy), 32'd0);
    check("lit_done_dec",  32'(a_dec),  32'd8);
    step(); start = 0; #2;
    check("lit_post_busy", 32'(a_busy), 32'd0);
    check("lit_post_done", 32'(a_done), 32'd0);
    step(); rOUT = 0;

    // range error on the 12-register instance (Ra = 13)
    load(32'h0680_0000);
    gra = 1; rIN = 1; #2;
    check("lit_rng_rin16", 32'(a_rin), 32'h2000);
    check("lit_rng_rin12", 32'(b_rin), 32'd0);
    step(); gra = 0; rIN = 0; #2;
    check("lit_rng_err12", 32'(b_err), 32'd1);
    check("lit_rng_err16", 32'(a_err), 32'd0);
    step(); step(); step(); #2;
    check("lit_rng_sticky", 32'(b_err), 32'd1);

    // reset mid-sequence
    load(32'h1A2C_0005);
    start = 1;
    step(); start = 0;
    step(); #2;
    check("lit_midB_sf", 32'(a_sf), 32'd2);
    clr = 0;
    step(); #2;
    check("lit_mr_op",   32'(a_op),   32'd0);
    check("lit_mr_ds",   a_ds,        32'd0);
    check("lit_mr_busy", 32'(a_busy), 32'd0);
    check("lit_mr_sf",   32'(a_sf),   32'd0);
    check("lit_mr_done", 32'(a_done), 32'd0);
    check("lit_mr_err",  32'(b_err),  32'd0);
    clr = 1;
    step(); step(); step(); step();
    #2;
    check("lit_mr_nodone", 32'(a_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
